ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of entries in the attached return-address stack.
REQ-002 SHALL have parameter AW, default 16, meaning the address width.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_valid  in  1  fetched instruction present
- fetch_pc  in  AW  PC of the fetched instruction
- fetch_instr  in  16  fetched instruction word
- fetch_stall  out  1  fetch held off while draining
- pred_valid  out  1  return-target prediction valid
- pred_target  out  AW  predicted return target
- ras_push  out  1  push to stack
- ras_data  out  AW  data pushed
- ras_pop  out  1  pop from stack
- ras_top  in  AW  stack top_of_stack
- ras_err  in  1  stack error
- commit_valid  in  1  instruction retiring
- commit_kind  in  2  00 none, 01 call, 10 ret, 11 reserved (ignored)
- flush  in  1  pipeline flush (mispredict)
- err_sticky  out  1  stack error seen

Function
REQ-004 SHALL decode CALL as fetch_instr[15:12]==OP_CALL and RET as fetch_instr[15:12]==OP_RET, only when fetch_valid=1, fetch_stall=0 and flush=0.
REQ-005 SHALL, on CALL with spec_depth<DEPTH, assert ras_push and drive ras_data=fetch_pc+1 (mod 2^AW) in the same cycle; spec_depth+1 at the next edge.
REQ-006 SHALL, on CALL with spec_depth==DEPTH, suppress ras_push and increment ovf_cnt (8-bit, saturating at 255).
REQ-007 SHALL, on RET with ovf_cnt>0, decrement ovf_cnt, leave ras_pop=0 and drive pred_valid=0.
REQ-008 SHALL, on RET with ovf_cnt==0 and spec_depth>0, assert ras_pop and pred_valid with pred_target=ras_top in the same cycle; spec_depth-1 at the next edge.
REQ-009 SHALL, on RET with ovf_cnt==0 and spec_depth==0, drive pred_valid=0 and ras_pop=0.
REQ-010 SHALL never assert ras_push and ras_pop in the same cycle.
REQ-011 SHALL track com_depth: call commit +1 (saturating at DEPTH), ret commit -1 (floor 0).
REQ-012 SHALL implement FSM IDLE/DRAIN:
- IDLE->DRAIN on flush when spec_depth>com_depth (after applying same-cycle commit).
- DRAIN: ras_pop=1 and fetch_stall=1 every cycle, spec_depth-1 per cycle.
- DRAIN->IDLE at the edge where spec_depth reaches com_depth.
REQ-013 SHALL, on flush with spec_depth<=com_depth, set com_depth:=spec_depth and stay in IDLE.
REQ-014 SHALL clear ovf_cnt on any flush.
REQ-015 SHALL re-evaluate on a flush during DRAIN and continue draining to the updated com_depth.
REQ-016 SHALL accept commits in DRAIN.
REQ-017 SHALL set err_sticky when ras_err=1 in a cycle where ras_push or ras_pop is asserted; err_sticky clears only on reset.

Reset
REQ-018 SHALL reset to: state IDLE, spec_depth=0, com_depth=0, ovf_cnt=0, err_sticky=0.
REQ-019 SHALL hold ras_push, ras_pop, pred_valid and fetch_stall at 0 while rst_n=0.
REQ-020 SHALL, on reset asserted mid-DRAIN, abandon the drain immediately; the stack is reset by the same rst_n.

Configuration
REQ-021 SHALL, with RAS_CTRL_STATS_EN defined, add 16-bit saturating output counters stat_pred (count of pred_valid cycles) and stat_drop (count of suppressed pushes), both reset to 0; without RAS_CTRL_STATS_EN these ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-022 SHALL take OP_CALL=4'hC, OP_RET=4'hD, RAS_DEPTH=8, the commit_kind enum and the IDLE/DRAIN state enum from package ras_pkg.
REQ-023 SHALL implement the statistics counters as instances of sub-module sat_counter.

Verification
REQ-024 SHALL cover: CALL at pc 0x0100 -> ras_push=1, ras_data=0x0101; following RET -> ras_pop=1, pred_target=0x0101.
REQ-025 SHALL cover: 9 CALLs -> 8 pushes, 9th suppressed with ovf_cnt=1; first RET -> pred_valid=0, no pop; second RET -> pops.
REQ-026 SHALL cover: RET at spec_depth=0 -> pred_valid=0, ras_pop=0, err_sticky stays 0.
REQ-027 SHALL cover: com_depth=1 with 3 speculative CALLs (spec_depth=4), then flush -> 3 cycles of ras_pop=1 and fetch_stall=1, then IDLE with spec_depth=1.
REQ-028 SHALL cover: flush coinciding with a call commit at spec_depth=3, com_depth=1 -> drain of 1 cycle to depth 2.
REQ-029 SHALL cover: forced ras_err=1 during a push -> err_sticky=1 until rst_n pulse.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared opcodes, depth default and enums for the return-address-stack controller.
// Optional statistics build: define RAS_CTRL_STATS_EN.
package ras_pkg;

    localparam logic [3:0] OP_CALL   = 4'hC;
    localparam logic [3:0] OP_RET    = 4'hD;
    localparam int         RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        CK_NONE = 2'b00,
        CK_CALL = 2'b01,
        CK_RET  = 2'b10,
        CK_RSVD = 2'b11
    } commit_kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } ras_state_e;

endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch, stack and commit signals of the RAS controller.
// master = pipeline/stack side, slave = ras_ctrl.
interface ras_ctrl_if #(
    parameter int AW = 16
) ();
    import ras_pkg::*;

    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic [15:0]   fetch_instr;
    logic          fetch_stall;
    logic          pred_valid;
    logic [AW-1:0] pred_target;
    logic          ras_push;
    logic [AW-1:0] ras_data;
    logic          ras_pop;
    logic [AW-1:0] ras_top;
    logic          ras_err;
    logic          commit_valid;
    commit_kind_e  commit_kind;
    logic          flush;
    logic          err_sticky;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, ras_top, ras_err,
        output commit_valid, commit_kind, flush,
        input  fetch_stall, pred_valid, pred_target, ras_push, ras_data,
        input  ras_pop, err_sticky
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, ras_top, ras_err,
        input  commit_valid, commit_kind, flush,
        output fetch_stall, pred_valid, pred_target, ras_push, ras_data,
        output ras_pop, err_sticky
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value.
// Used by ras_ctrl statistics (RAS_CTRL_STATS_EN).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count events until all ones, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: speculative push/pop, overflow shadow
// count, and drain back to committed depth on flush. Stats: RAS_CTRL_STATS_EN.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ras_ctrl_if.slave   bus
`ifdef RAS_CTRL_STATS_EN
    ,
    output logic [15:0] stat_pred,
    output logic [15:0] stat_drop
`endif
);

    localparam int            DW   = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    localparam logic [DW-1:0] D1   = DW'(1);
    localparam logic [AW-1:0] A1   = AW'(1);

    ras_state_e    r_state;
    logic [DW-1:0] r_spec;
    logic [DW-1:0] r_com;
    logic [7:0]    r_ovf;
    logic          r_err;

    logic [3:0]    w_op;
    logic          w_drain;
    logic          w_fire;
    logic          w_call;
    logic          w_ret;
    logic          w_push;
    logic          w_drop;
    logic          w_ovf_ret;
    logic          w_pred;
    logic          w_pop;
    logic          w_ccall;
    logic          w_cret;
    logic [DW-1:0] w_com_nxt;
    logic [DW-1:0] w_spec_dec;
    logic          w_unused;

    assign w_op      = bus.fetch_instr[15:12];
    assign w_unused  = ^bus.fetch_instr[11:0];
    assign w_drain   = (r_state == ST_DRAIN);
    assign w_fire    = bus.fetch_valid & ~w_drain & ~bus.flush;
    assign w_call    = w_fire & (w_op == OP_CALL);
    assign w_ret     = w_fire & (w_op == OP_RET);
    assign w_push    = w_call & (r_spec < DMAX);
    assign w_drop    = w_call & ~(r_spec < DMAX);
    assign w_ovf_ret = w_ret & (r_ovf != 8'd0);
    assign w_pred    = w_ret & (r_ovf == 8'd0) & (r_spec != '0);
    assign w_pop     = w_pred | w_drain;

    assign w_ccall    = bus.commit_valid & (bus.commit_kind == CK_CALL);
    assign w_cret     = bus.commit_valid & (bus.commit_kind == CK_RET);
    assign w_spec_dec = r_spec - D1;

    // committed depth after this cycle's retiring call/ret
    always_comb begin
        w_com_nxt = r_com;
        if (w_ccall && (r_com < DMAX)) begin
            w_com_nxt = r_com + D1;
        end else if (w_cret && (r_com != '0)) begin
            w_com_nxt = r_com - D1;
        end
    end

    // stack strobes are forced quiet while reset is held
    assign bus.ras_push    = w_push & rst_n;
    assign bus.ras_pop     = w_pop & rst_n;
    assign bus.pred_valid  = w_pred & rst_n;
    assign bus.fetch_stall = w_drain & rst_n;
    assign bus.ras_data    = bus.fetch_pc + A1;
    assign bus.pred_target = bus.ras_top;
    assign bus.err_sticky  = r_err;

    // IDLE/DRAIN FSM with speculative/committed depth and overflow count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_spec  <= '0;
            r_com   <= '0;
            r_ovf   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= r_err | (bus.ras_err & (w_push | w_pop));
            if (bus.flush) begin
                r_ovf <= 8'd0;
            end else if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end else if (w_ovf_ret) begin
                r_ovf <= r_ovf - 8'd1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    r_com <= w_com_nxt;
                    if (bus.flush) begin
                        if (r_spec > w_com_nxt) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_com <= r_spec;
                        end
                    end else if (w_push) begin
                        r_spec <= r_spec + D1;
                    end else if (w_pred) begin
                        r_spec <= w_spec_dec;
                    end
                end
                ST_DRAIN: begin
                    r_spec <= w_spec_dec;
                    r_com  <= w_com_nxt;
                    if (w_spec_dec <= w_com_nxt) begin
                        r_state <= ST_IDLE;
                        r_com   <= w_spec_dec;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAS_CTRL_STATS_EN
    sat_counter #(.W(16)) u_stat_pred (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_pred),
        .o_cnt (stat_pred)
    );

    sat_counter #(.W(16)) u_stat_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_drop),
        .o_cnt (stat_drop)
    );
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed call/ret/flush/commit vectors,
// behavioural stack model feeding ras_top.
module tb_ras_ctrl;
    import ras_pkg::*;

    typedef struct {
        string       nm;
        logic        push;
        logic        pop;
        logic        pv;
        logic        stall;
        logic [15:0] val;
    } ev_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ev_t  sb[$];

    ras_ctrl_if #(.AW(16)) bus ();

`ifdef RAS_CTRL_STATS_EN
    logic [15:0] stat_pred;
    logic [15:0] stat_drop;
`endif

    ras_ctrl #(.DEPTH(8), .AW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef RAS_CTRL_STATS_EN
        ,
        .stat_pred (stat_pred),
        .stat_drop (stat_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external stack model
    logic [15:0] stk [0:15];
    logic [4:0]  sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 5'd0;
        end else if (bus.ras_push) begin
            stk[sp[3:0]] <= bus.ras_data;
            sp <= sp + 5'd1;
        end else if (bus.ras_pop && (sp != 5'd0)) begin
            sp <= sp - 5'd1;
        end
    end

    always_comb begin
        bus.ras_top = 16'h0000;
        if (sp != 5'd0) bus.ras_top = stk[sp[3:0] - 4'd1];
    end

    // monitor: every output event must match the next expected one
    always @(negedge clk) begin
        if (rst_n && (bus.ras_push || bus.ras_pop || bus.pred_valid)) begin
            ev_t         e;
            logic [15:0] av;
            av = bus.ras_push ? bus.ras_data :
                 (bus.pred_valid ? bus.pred_target : 16'h0000);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got push=%0b pop=%0b pv=%0b stall=%0b val=%h, required no event",
                         bus.ras_push, bus.ras_pop, bus.pred_valid, bus.fetch_stall, av);
            end else begin
                e = sb.pop_front();
                if (bus.ras_push !== e.push || bus.ras_pop !== e.pop ||
                    bus.pred_valid !== e.pv || bus.fetch_stall !== e.stall ||
                    ((e.push || e.pv) && av !== e.val)) begin
                    errors++;
                    $display("FAIL %s: got push=%0b pop=%0b pv=%0b stall=%0b val=%h, required push=%0b pop=%0b pv=%0b stall=%0b val=%h",
                             e.nm, bus.ras_push, bus.ras_pop, bus.pred_valid, bus.fetch_stall, av,
                             e.push, e.pop, e.pv, e.stall, e.val);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.fetch_valid  = 1'b0;
        bus.fetch_pc     = 16'h0000;
        bus.fetch_instr  = 16'h0000;
        bus.ras_err      = 1'b0;
        bus.commit_valid = 1'b0;
        bus.commit_kind  = CK_NONE;
        bus.flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic call(input logic [15:0] pc, input logic ep);
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 16'hC123;
        bus.fetch_pc    = pc;
        if (ep) sb.push_back('{"call_push", 1'b1, 1'b0, 1'b0, 1'b0, pc + 16'd1});
        tick();
        idle();
    endtask

    task automatic ret(input logic epv, input logic [15:0] tgt);
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 16'hD0A5;
        bus.fetch_pc    = 16'h7777;
        if (epv) sb.push_back('{"ret_pred", 1'b0, 1'b1, 1'b1, 1'b0, tgt});
        tick();
        idle();
    endtask

    task automatic commit_call();
        bus.commit_valid = 1'b1;
        bus.commit_kind  = CK_CALL;
        tick();
        idle();
    endtask

    task automatic do_flush(input logic ccall);
        bus.flush = 1'b1;
        if (ccall) begin
            bus.commit_valid = 1'b1;
            bus.commit_kind  = CK_CALL;
        end
        tick();
        idle();
    endtask

    // drain cycles, with a CALL offered that must be held off
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{"drain_pop", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
            bus.fetch_valid = 1'b1;
            bus.fetch_instr = 16'hC000;
            bus.fetch_pc    = 16'hBEE0;
            tick();
            idle();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pop", {31'd0, bus.ras_pop}, 32'd0);
        chk("rst_stall", {31'd0, bus.fetch_stall}, 32'd0);
        chk("rst_err_sticky", {31'd0, bus.err_sticky}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 16'hC000;
        bus.fetch_pc    = 16'h0100;
        #3;
        chk("rst_push", {31'd0, bus.ras_push}, 32'd0);
        chk("rst_pred", {31'd0, bus.pred_valid}, 32'd0);
        chk("rst_stall0", {31'd0, bus.fetch_stall}, 32'd0);
        chk("rst_err0", {31'd0, bus.err_sticky}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        tick();

        // basic call then return
        call(16'h0100, 1'b1);
        ret(1'b1, 16'h0101);

        // return on empty stack, error line raised but nothing strobed
        bus.ras_err = 1'b1;
        ret(1'b0, 16'h0000);
        tick();
        chk("empty_ret_err", {31'd0, bus.err_sticky}, 32'd0);

        // overflow: 8 pushes, 9th suppressed, first ret swallowed
        for (int i = 0; i < 9; i++) begin
            call(16'h0200 + 16'(i), i < 8);
        end
        ret(1'b0, 16'h0000);
        ret(1'b1, 16'h0208);

        // flush with com_depth=0, spec_depth=7: reset lands mid-drain
        do_flush(1'b0);
        drain(2);
        rst_n = 1'b0;
        #1;
        chk("mid_drain_pop", {31'd0, bus.ras_pop}, 32'd0);
        chk("mid_drain_stall", {31'd0, bus.fetch_stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // com_depth=1, spec_depth=4, flush drains 3
        call(16'h0300, 1'b1);
        commit_call();
        call(16'h0310, 1'b1);
        call(16'h0320, 1'b1);
        call(16'h0330, 1'b1);
        do_flush(1'b0);
        drain(3);
        chk("drain_done_stall", {31'd0, bus.fetch_stall}, 32'd0);
        ret(1'b1, 16'h0301);
        ret(1'b0, 16'h0000);

        // flush with coincident call commit: spec 3, com 1 -> 2
        do_reset();
        call(16'h0400, 1'b1);
        commit_call();
        call(16'h0410, 1'b1);
        call(16'h0420, 1'b1);
        do_flush(1'b1);
        drain(1);
        chk("drain1_done_stall", {31'd0, bus.fetch_stall}, 32'd0);
        ret(1'b1, 16'h0411);
        ret(1'b1, 16'h0401);
        ret(1'b0, 16'h0000);

        // stack error during a push is sticky until reset
        do_reset();
        bus.ras_err = 1'b1;
        call(16'h0500, 1'b1);
        chk("err_set", {31'd0, bus.err_sticky}, 32'd1);
        repeat (3) tick();
        chk("err_hold", {31'd0, bus.err_sticky}, 32'd1);
        do_reset();
        chk("err_after_rst", {31'd0, bus.err_sticky}, 32'd0);

        repeat (2) tick();
        chk("sb_leftover", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
